// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
// shift_pipe : pipelined log2(WIDTH)-level barrel shifter/rotator with
//              valid/ready handshake (ROL, SLL, ROR, SRA).
// Revision   : 1.0
// ============================================================================
module shift_pipe #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] In,
   input  logic [CNT_W-1:0] Cnt,
   input  logic [1:0]       Op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Out,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;

   if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || CNT_W != $clog2(WIDTH)) begin : g_bad_width
      $error("shift_pipe: WIDTH must be a power of two >= 4 and CNT_W must be $clog2(WIDTH)");
   end

   function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       op,
                                                    input int               s);
      logic [WIDTH-1:0] r;
      case (op)
         OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
         OP_SLL:  r = d << s;
         OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
         default: r = $unsigned($signed(d) >>> s);
      endcase
      return r;
   endfunction

   logic [CNT_W-1:0] vld;
   logic [CNT_W-1:0] adv;
   logic [WIDTH-1:0] stg_data [CNT_W];
   logic [CNT_W-1:0] stg_cnt  [CNT_W];
   logic [1:0]       stg_op   [CNT_W];

   // A stage may load when it is empty or its successor is moving on this cycle.
   always_comb begin
      adv            = '0;
      adv[CNT_W-1]   = !vld[CNT_W-1] | out_ready;
      for (int i = CNT_W - 2; i >= 0; i--) begin
         adv[i] = !vld[i] | adv[i+1];
      end
   end

   assign in_ready  = adv[0] & !rst;
   assign Out       = stg_data[CNT_W-1];
   assign out_valid = vld[CNT_W-1];

   for (genvar i = 0; i < CNT_W; i++) begin : g_stage
      localparam int SH = 1 << i;

      logic [WIDTH-1:0] src_data;
      logic [CNT_W-1:0] src_cnt;
      logic [1:0]       src_op;
      logic             src_vld;
      logic [WIDTH-1:0] data_q;
      logic [CNT_W-1:0] cnt_q;
      logic [1:0]       op_q;
      logic             vld_q;

      if (i == 0) begin : g_head
         assign src_data = In;
         assign src_cnt  = Cnt;
         assign src_op   = Op;
         assign src_vld  = in_valid;
      end else begin : g_body
         assign src_data = stg_data[i-1];
         assign src_cnt  = stg_cnt[i-1];
         assign src_op   = stg_op[i-1];
         assign src_vld  = vld[i-1];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
         end else if (adv[i]) begin
            vld_q  <= src_vld;
            data_q <= src_cnt[i] ? shift_level(src_data, src_op, SH) : src_data;
            cnt_q  <= src_cnt;
            op_q   <= src_op;
         end
      end

      assign vld[i]      = vld_q;
      assign stg_data[i] = data_q;
      assign stg_cnt[i]  = cnt_q;
      assign stg_op[i]   = op_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
// tb_shift_pipe : scoreboard bench for shift_pipe (WIDTH=16).
// Revision      : 1.0
// ============================================================================
module tb_shift_pipe;

   localparam int W  = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  In;
   logic [CW-1:0] Cnt;
   logic [1:0]    Op;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  Out;
   logic          out_valid;
   logic          out_ready;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [W-1:0]  exp_q [$];

   shift_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .In(In), .Cnt(Cnt), .Op(Op),
      .in_valid(in_valid), .in_ready(in_ready),
      .Out(Out), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Whole-word reference: rotations through a doubled word, shifts via plain operators.
   function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [CW-1:0] c,
                                          input logic [1:0] op);
      logic [2*W-1:0] dd;
      logic [2*W-1:0] t;
      dd = {d, d};
      case (op)
         2'b00:   begin t = dd << c; return t[2*W-1:W]; end
         2'b01:   return d << c;
         2'b10:   begin t = dd >> c; return t[W-1:0]; end
         default: return $unsigned($signed(d) >>> c);
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic [CW-1:0] c, input logic [1:0] op,
                       input logic [W-1:0] exp, output int waits);
      bit done;
      done  = 0;
      waits = 0;
      In = d; Cnt = c; Op = op; in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(exp);
            done = 1;
         end else begin
            waits++;
            if (waits > 200) begin
               check("send_timeout", waits, 0);
               done = 1;
            end
         end
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic measure_latency(output int lat);
      lat = 1;
      while (!out_valid && lat < 50) begin
         step();
         lat++;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      step();
      check("drain_empty", exp_q.size(), 0);
   endtask

   // Monitor: pops on every output transfer and checks stability while stalled.
   logic [W-1:0] prev_out;
   bit           prev_hold = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_hold = 0;
         end else begin
            if (prev_hold) begin
               check("hold_out", Out, prev_out);
               check("hold_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
               else check("data", Out, exp_q.pop_front());
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = Out;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   logic [W-1:0]  bp_d [6];
   logic [CW-1:0] bp_c [6];
   logic [1:0]    bp_o [6];

   initial begin
      int waits, lat, acc;
      bit took;
      logic [W-1:0]  rd;
      logic [CW-1:0] rc;
      logic [1:0]    ro;

      // Reset with in_valid asserted
      rst = 1'b1; in_valid = 1'b1; In = 16'hFFFF; Cnt = 4'd3; Op = 2'b01; out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         check("rst_out", Out, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 0);
      end
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      step();

      // Op sweep with latency
      for (int op = 0; op < 4; op++) begin
         logic [W-1:0] e;
         case (op)
            0: e = 16'h4218;
            1: e = 16'h4210;
            2: e = 16'h1842;
            default: e = 16'hF842;
         endcase
         send(16'h8421, 4'd4, op[1:0], e, waits);
         measure_latency(lat);
         check("latency", lat, 4);
         step();
      end

      // Boundaries, back to back
      for (int op = 0; op < 4; op++) send(16'hF00F, 4'd0, op[1:0], 16'hF00F, waits);
      send(16'h8001, 4'd15, 2'b00, 16'hC000, waits);
      send(16'h8001, 4'd15, 2'b01, 16'h8000, waits);
      send(16'h8001, 4'd15, 2'b11, 16'hFFFF, waits);
      drain();

      // Back-pressure: 6 items into a stalled pipe
      for (int k = 0; k < 6; k++) begin
         bp_d[k] = W'($urandom); bp_c[k] = CW'($urandom); bp_o[k] = 2'($urandom);
      end
      out_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 10; k++) begin
         In = bp_d[acc]; Cnt = bp_c[acc]; Op = bp_o[acc]; in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(model(bp_d[acc], bp_c[acc], bp_o[acc]));
            acc++;
         end
         step();
      end
      check("bp_accepted", acc, 4);
      @(negedge clk);
      check("bp_full_in_ready", in_ready, 0);
      step();
      out_ready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         if (acc < 6) begin
            In = bp_d[acc]; Cnt = bp_c[acc]; Op = bp_o[acc]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         check("bp_drain_valid", out_valid, 1);
         if (in_valid && in_ready) begin
            exp_q.push_back(model(bp_d[acc], bp_c[acc], bp_o[acc]));
            acc++;
         end
         step();
      end
      in_valid = 1'b0;
      check("bp_all_accepted", acc, 6);
      drain();

      // Bubble collapse
      out_ready = 1'b0;
      send(16'h1234, 4'd1, 2'b00, model(16'h1234, 4'd1, 2'b00), waits);
      step(); step();
      send(16'hA5C3, 4'd7, 2'b11, model(16'hA5C3, 4'd7, 2'b11), waits);
      for (int k = 0; k < 4; k++) step();
      @(negedge clk);
      check("bubble_in_ready_two_held", in_ready, 1);
      step();
      send(16'h0F0F, 4'd9, 2'b10, model(16'h0F0F, 4'd9, 2'b10), waits);
      check("bubble_c_waits", waits, 0);
      send(16'hBEEF, 4'd3, 2'b01, model(16'hBEEF, 4'd3, 2'b01), waits);
      check("bubble_d_waits", waits, 0);
      for (int k = 0; k < 4; k++) step();
      @(negedge clk);
      check("bubble_full_in_ready", in_ready, 0);
      step();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bubble_packed_valid", out_valid, 1);
         step();
      end
      drain();

      // Mid-flight reset
      for (int k = 0; k < 3; k++) begin
         rd = W'($urandom); rc = CW'($urandom); ro = 2'($urandom);
         send(rd, rc, ro, model(rd, rc, ro), waits);
      end
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_in_ready", in_ready, 0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("midrst_out_valid", out_valid, 0);
         step();
      end
      send(16'h8421, 4'd4, 2'b10, 16'h1842, waits);
      measure_latency(lat);
      check("midrst_latency", lat, 4);
      drain();

      // Randomized traffic
      took = 0;
      for (int k = 0; k < 400; k++) begin
         if (!in_valid && ($urandom % 3) != 0) begin
            In = W'($urandom); Cnt = CW'($urandom); Op = 2'($urandom); in_valid = 1'b1;
         end
         out_ready = ($urandom % 4) != 0;
         @(negedge clk);
         took = 0;
         if (in_valid && in_ready) begin
            exp_q.push_back(model(In, Cnt, Op));
            took = 1;
         end
         step();
         if (took) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter/rotator that generalises the single-level 16-bit shift-by-4 cell into a full log2(WIDTH)-level shifter with four operations and a valid/ready handshake. Each shift level is one register stage, so a new operand can be accepted every cycle. It sits between the execute-stage operand muxes and the ALU result mux, and it stalls cleanly under downstream back-pressure.

## Interface
- WIDTH, 16: data width. Must be a power of two and at least 4; any other value is an elaboration error.
- CNT_W, $clog2(WIDTH): shift-amount width. Derived; never overridden.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- In  input  WIDTH  operand.
- Cnt  input  CNT_W  shift amount, 0..WIDTH-1.
- Op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRA.
- in_valid  input  1  In/Cnt/Op valid this cycle.
- in_ready  output  1  pipeline accepts this cycle.
- Out  output  WIDTH  result.
- out_valid  output  1  Out valid.
- out_ready  input  1  consumer takes Out this cycle.

## Operation
- CNT_W stages, S0..S(CNT_W-1). Each stage holds a valid bit, a data word, Cnt, and Op.
- Stage i shifts by 2^i when Cnt[i]=1 and passes the word unchanged when Cnt[i]=0. Cnt and Op travel with the data.
- S0 applies level 0 to In as it captures it. Stage i>0 applies level i to the data from stage i-1 as it captures it.
- Out = S(CNT_W-1) data. out_valid = S(CNT_W-1) valid.
- Fill rules:
  - SLL: vacated low bits are 0.
  - ROL/ROR: bits wrap modulo WIDTH.
  - SRA: vacated high bits copy the current MSB, which equals In[WIDTH-1].
  - Logical right shift is not provided.
- Advance chain:
  - adv_last = !v_last | out_ready.
  - adv_i = !v_i | adv_(i+1).
  - in_ready = adv_0 & !rst.
- Stage i loads from its predecessor when adv_i=1.
  - S0's predecessor is the input port, qualified by in_valid.
  - The loaded valid is the predecessor's valid.
  - When adv_i=0, the stage holds all of its fields.
- Bubbles collapse: an empty stage always accepts, even when downstream is stalled.
- Out, Cnt and Op of a held item stay stable for as long as out_valid=1 and out_ready=0.
- Cnt=0: Out equals In for every Op.
- Handshake transfer: an item moves in when in_valid & in_ready, and out when out_valid & out_ready. Both may occur in the same cycle.

## Timing
- Reset values (one cycle after rst is sampled high):
  - All stage valid bits are 0.
  - All stage data, Cnt and Op registers are 0.
  - Out = 0 and out_valid = 0.
  - in_ready = 0 while rst is high.
- Reset mid-operation discards every in-flight item. No partial result reaches Out.
- Latency: an item accepted at edge k gives out_valid=1 after edge k+CNT_W-1 (4 cycles for WIDTH=16), provided there is no stall.
- Throughput: one item per cycle while out_ready=1.
- out_ready reaches in_ready through a combinational path of CNT_W AND/OR levels. This is accepted; there are no other combinational input-to-output paths.
- Full condition: all CNT_W stages are valid and out_ready=0, which drives in_ready=0. in_ready=1 again in the same cycle out_ready rises.
- Occupancy never exceeds CNT_W. Items are never dropped, duplicated or reordered.

## Test plan
- Reset/idle: hold rst for 2 cycles with in_valid=1.
  - Expect Out=0, out_valid=0 and in_ready=0 throughout.
  - After rst drops, expect in_ready=1.
- Op sweep, WIDTH=16, In=16'h8421, Cnt=4, out_ready=1. Each result appears 4 cycles after acceptance:
  - ROL -> 16'h4218
  - SLL -> 16'h4210
  - ROR -> 16'h1842
  - SRA -> 16'hF842
- Boundaries:
  - In=16'hF00F, Cnt=0, any Op -> 16'hF00F.
  - In=16'h8001, Cnt=15: ROL -> 16'hC000, SLL -> 16'h8000, SRA -> 16'hFFFF.
- Back-pressure: stream 6 back-to-back items with out_ready=0.
  - Expect in_ready to fall after exactly 4 acceptances, with Out held stable.
  - Raise out_ready: the remaining items drain in order at 1 per cycle, with none lost.
- Bubble collapse: accept item A, wait 2 idle cycles, accept item B, with out_ready=0.
  - Expect B to sit directly behind A (both held).
  - in_ready stays 1 until 4 items are held.
- Mid-flight reset: accept 3 items, assert rst for 1 cycle, release.
  - Expect out_valid to stay 0 with no stale Out.
  - A new item then returns after the normal 4-cycle latency.
